mux_scan: RTL
=============

MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter W, default 16, data width per channel; legal range 1..32.
REQ-003 Parameter DWELL, default 500, clock cycles spent on each channel in scan mode; legal range >= 1.
REQ-004 Derived SW = max(1, clog2(N)), width of channel index.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 din  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
REQ-008 sel  input  SW  manual channel select, used only when mode=0.
REQ-009 mode  input  1  0 = manual select, 1 = automatic scan.
REQ-010 hold  input  1  freezes scan progress when mode=1; ignored when mode=0.
REQ-011 dout  output  W  registered data of the current channel.
REQ-012 ch  output  SW  current channel index, registered.
REQ-013 ch_chg  output  1  one-cycle pulse, high in the cycle ch first shows a new value.
REQ-014 wrap  output  1  one-cycle pulse, high in the cycle ch shows 0 after a scan step from N-1.

Function
REQ-015 Internal dwell counter cnt SHALL hold values 0..DWELL-1 and be sized to represent DWELL-1.
REQ-016 dout SHALL update every edge to the din slice selected by the registered ch value; latency din->dout = 1 cycle, ch change->dout = 1 cycle.
REQ-017 Manual (mode=0), sel < N, sel != ch: ch <= sel, ch_chg pulses next cycle.
REQ-018 Manual, sel == ch: ch unchanged, no pulse.
REQ-019 Manual, sel >= N (only possible when N not a power of 2): ch unchanged, no pulse; out-of-range never reaches ch.
REQ-020 Manual: cnt <= 0 every edge; wrap never asserted.
REQ-021 Scan (mode=1, hold=0), cnt < DWELL-1: cnt <= cnt+1, ch unchanged.
REQ-022 Scan, hold=0, cnt == DWELL-1: cnt <= 0; ch <= ch+1, or 0 if ch == N-1; ch_chg pulses; wrap pulses only on the N-1->0 step.
REQ-023 DWELL=1: ch advances every cycle; ch_chg stays high continuously while scanning; wrap high one cycle in every N.
REQ-024 Scan, hold=1: cnt and ch frozen, no pulses; dout keeps tracking din of the frozen channel.
REQ-025 Mode 0->1: scanning starts from the current ch with cnt=0, so first advance occurs DWELL cycles after mode rises.
REQ-026 Mode 1->0 mid-dwell: cnt discarded (cleared), ch taken from sel per REQ-017..019 on that same edge.
REQ-027 ch_chg and wrap SHALL be registered outputs, never combinational from inputs.
REQ-028 At most one ch update per edge; mode, sel, hold sampled only at rising edge.

Reset
REQ-029 rst_n low SHALL immediately force ch=0, cnt=0, dout=0, ch_chg=0, wrap=0, independent of clk.
REQ-030 While rst_n low, all inputs ignored; state held at reset values.
REQ-031 First rising edge after rst_n high SHALL operate normally from reset state; reset asserted mid-dwell or mid-pulse aborts it with no residual pulse.

Verification
REQ-032 N=4,W=16,DWELL=3, mode=1, din={16'hD,16'hC,16'hB,16'hA} -> ch sequence 0,0,0,1,1,1,2,...; dout 16'hA,...,16'hB one cycle after ch=1; wrap single pulse when ch 3->0 (cycle 12).
REQ-033 N=3, mode=0, sel=2 then sel=3 -> ch=2 with one ch_chg pulse; sel=3 leaves ch=2, no pulse; dout = channel 2 data throughout.
REQ-034 DWELL=3, mode=1, hold=1 for 5 cycles after ch reaches 1 with cnt=1 -> ch stays 1 for 5 extra cycles, no pulses; after release ch->2 exactly 2 cycles later.
REQ-035 mode=0 sel=2, then mode=1 at edge t -> ch=3 appears at edge t+DWELL; mode back to 0 with sel=0 mid-dwell -> ch=0 next edge, cnt=0.
REQ-036 DWELL=1, N=4 -> ch 0,1,2,3,0 each cycle; ch_chg constant high; wrap high 1 cycle in 4.
REQ-037 rst_n pulled low between clock edges mid-dwell with ch=2 -> ch, dout, pulses read 0 before next edge; scan restarts at ch=0 with full DWELL after release.

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: N-channel data multiplexer with manual select and automatic scan.
//
// In manual mode (mode=0) the channel index follows sel, provided sel names a
// real channel. In scan mode (mode=1) the block stays on each channel for
// DWELL clock cycles and then steps to the next one, returning to channel 0
// after channel N-1. The hold input freezes scan progress.
//
// Ports:
//   clk     single clock; all state changes on the rising edge
//   rst_n   asynchronous, active-low reset
//   din     packed channel data; channel k is din[k*W +: W]
//   sel     manual channel select (used only when mode=0)
//   mode    0 = manual select, 1 = automatic scan
//   hold    freezes scan progress while mode=1; ignored in manual mode
//   dout    registered data of the current channel
//   ch      registered current channel index
//   ch_chg  one-cycle pulse in the cycle ch first shows a new value
//   wrap    one-cycle pulse in the cycle ch shows 0 after a scan step from N-1
module mux_scan #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int DWELL = 500,
  localparam int SW   = (N > 2) ? $clog2(N) : 1,
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           hold,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  ch,
  output logic           ch_chg,
  output logic           wrap
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);
  localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [SW-1:0] ch_next;
  logic          step_wrap;
  logic          sel_valid;

  // sel is compared one bit wider so that a non-power-of-two N can reject
  // the unused codes without the compare collapsing to a constant.
  assign sel_valid = ({1'b0, sel} < N_EXT);

  // Next-state logic. The dwell counter defaults to zero, which covers
  // manual mode, the step edge, and leaving scan mode mid-dwell in one place.
  // In manual mode an out-of-range sel simply leaves ch where it is.
  always_comb begin
    cnt_next  = '0;
    ch_next   = ch;
    step_wrap = 1'b0;
    if (mode) begin
      if (hold) begin
        cnt_next = cnt;
      end else if (cnt == CNT_LAST) begin
        if (ch == CH_LAST) begin
          ch_next   = '0;
          step_wrap = 1'b1;
        end else begin
          ch_next = ch + 1'b1;
        end
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end else if (sel_valid) begin
      ch_next = sel;
    end
  end

  // State and output registers. dout is taken from the channel selected by
  // the current (already registered) ch, so a channel change reaches dout one
  // cycle after it reaches ch. Both pulses are registered so they line up with
  // the cycle in which ch shows its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      ch     <= '0;
      dout   <= '0;
      ch_chg <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      ch     <= ch_next;
      dout   <= din[int'(ch) * W +: W];
      ch_chg <= (ch_next != ch);
      wrap   <= step_wrap;
    end
  end

endmodule
